// File: rtl/vga_fb_ctrl_if.sv
// Producer-side port of the VGA framebuffer controller:
// back-buffer writes, swap request/acknowledge and scan-out status.
interface vga_fb_ctrl_if #(
    parameter int AW    = 15,
    parameter int PIX_W = 12
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             swap_req;
    logic             swap_done;
    logic             disp_bank;
    logic             vblank;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output swap_req,
        input  swap_done,
        input  disp_bank,
        input  vblank
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  swap_req,
        output swap_done,
        output disp_bank,
        output vblank
    );
endinterface

// File: rtl/vga_fb_ctrl.sv
// Parametrised VGA timing generator with a double-buffered framebuffer;
// buffer swaps are deferred to the first blank line so scan-out never tears.
module vga_fb_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 2,
    parameter int CH_W        = 4,
    parameter int AW          = $clog2((H_ACTIVE >> SCALE_SHIFT) *
                                       (V_ACTIVE >> SCALE_SHIFT))
) (
    input  logic          clk,
    input  logic          rst,
    vga_fb_ctrl_if.slave  fb,
    output logic          VGA_HSYNC,
    output logic          VGA_VSYNC,
    output logic          VGA_BLANK_N,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H    = V_ACTIVE >> SCALE_SHIFT;
    localparam int DEPTH   = FB_W * FB_H;
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PIX_W   = 3 * CH_W;

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             swap_pt;
    logic             disp_bank;
    logic             swap_pending;
    logic             swap_done;
    logic             wr_ok;

    logic             act0;
    logic             hs0;
    logic             vs0;
    logic [IW-1:0]    addr0;

    logic [IW-1:0]    addr1;
    logic             act1;
    logic             hs1;
    logic             vs1;

    logic [PIX_W-1:0] rd0;
    logic [PIX_W-1:0] rd1;
    logic             bank2;
    logic             act2;
    logic             hs2;
    logic             vs2;
    logic [PIX_W-1:0] pix2;

    logic [PIX_W-1:0] mem0 [DEPTH];
    logic [PIX_W-1:0] mem1 [DEPTH];

    function automatic logic [7:0] expand(input logic [CH_W-1:0] c);
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o[7-i] = c[CH_W-1-(i % CH_W)];
        end
        return o;
    endfunction

    assign h_wrap = (h_cnt == HW'(H_TOTAL - 1));
    assign v_wrap = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // The swap is committed on the edge that enters the first blank line,
    // so disp_bank and swap_done are both visible while v_cnt == V_ACTIVE.
    assign swap_pt = h_wrap && (v_cnt == VW'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bank    <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else if (swap_pt && (swap_pending || fb.swap_req)) begin
            disp_bank    <= ~disp_bank;
            swap_pending <= 1'b0;
            swap_done    <= 1'b1;
        end else begin
            swap_done <= 1'b0;
            if (fb.swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign fb.disp_bank = disp_bank;
    assign fb.swap_done = swap_done;
    assign fb.vblank    = (32'(v_cnt) >= V_ACTIVE);

    assign act0 = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs0  = (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END);
    assign vs0  = (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END);

    // Outside the visible area the address is parked at 0 to keep reads in range.
    assign addr0 = act0 ? IW'(((32'(v_cnt) >> SCALE_SHIFT) * FB_W) +
                              (32'(h_cnt) >> SCALE_SHIFT))
                        : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr1 <= '0;
            act1  <= 1'b0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
        end else begin
            addr1 <= addr0;
            act1  <= act0;
            hs1   <= hs0;
            vs1   <= vs0;
        end
    end

    assign wr_ok = fb.wr_en && (32'(fb.wr_addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (wr_ok && disp_bank) begin
            mem0[IW'(fb.wr_addr)] <= fb.wr_data;
        end
        rd0 <= mem0[addr1];
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !disp_bank) begin
            mem1[IW'(fb.wr_addr)] <= fb.wr_data;
        end
        rd1 <= mem1[addr1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank2 <= 1'b0;
            act2  <= 1'b0;
            hs2   <= 1'b0;
            vs2   <= 1'b0;
        end else begin
            bank2 <= disp_bank;
            act2  <= act1;
            hs2   <= hs1;
            vs2   <= vs1;
        end
    end

    assign pix2 = bank2 ? rd1 : rd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            VGA_HSYNC   <= ~HS_POL;
            VGA_VSYNC   <= ~VS_POL;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            VGA_HSYNC   <= hs2 ? HS_POL : ~HS_POL;
            VGA_VSYNC   <= vs2 ? VS_POL : ~VS_POL;
            VGA_BLANK_N <= act2;
            if (act2) begin
                VGA_R <= expand(pix2[3*CH_W-1 -: CH_W]);
                VGA_G <= expand(pix2[2*CH_W-1 -: CH_W]);
                VGA_B <= expand(pix2[CH_W-1 -: CH_W]);
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl on a 4x2 framebuffer with 14x7 timing.
module tb_vga_fb_ctrl;
    logic       clk;
    logic       rst;
    logic       VGA_HSYNC;
    logic       VGA_VSYNC;
    logic       VGA_BLANK_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int dbank_m;
    logic [11:0] mdl [2][8];

    vga_fb_ctrl_if #(.AW(4), .PIX_W(12)) fb();

    vga_fb_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .SCALE_SHIFT(1), .CH_W(4), .AW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fb(fb),
        .VGA_HSYNC(VGA_HSYNC),
        .VGA_VSYNC(VGA_VSYNC),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter state the DUT should hold; the pins show the state 3 cycles back.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_act(input int c);
        if (c < 0) return 1'b0;
        return ((c % 14) < 8) && (((c / 14) % 7) < 4);
    endfunction

    function automatic logic [23:0] exp_rgb(input int c);
        int a;
        logic [11:0] d;
        if (!exp_act(c)) return 24'h0;
        a = (((c / 14) % 7) >> 1) * 4 + ((c % 14) >> 1);
        d = mdl[dbank_m][a];
        return {d[11:8], d[11:8], d[7:4], d[7:4], d[3:0], d[3:0]};
    endfunction

    task automatic wait_st(input int h, input int v);
        int k = 0;
        while (!((cyc % 14) == h && ((cyc / 14) % 7) == v) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("wait_tmo", 1, 0);
    endtask

    task automatic pulse_req();
        fb.swap_req = 1'b1;
        @(negedge clk);
        fb.swap_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [11:0] d);
        fb.wr_en   = 1'b1;
        fb.wr_addr = 4'(a);
        fb.wr_data = d;
        if (a < 8) mdl[1-dbank_m][a] = d;
        @(negedge clk);
        fb.wr_en = 1'b0;
    endtask

    task automatic wait_swap(output int k);
        k = 0;
        while (!fb.swap_done && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("swap_tmo", 1, 0);
    endtask

    task automatic check_frame(input string tag);
        int err = 0;
        for (int i = 0; i < 98; i++) begin
            if ({VGA_R, VGA_G, VGA_B} !== exp_rgb(cyc - 3) ||
                VGA_BLANK_N !== exp_act(cyc - 3)) err++;
            @(negedge clk);
        end
        chk(tag, err, 0);
    endtask

    // Releases reset at a falling edge and checks two frames of timing.
    task automatic run_timing(input string tag);
        int hs_err = 0;
        int vs_err = 0;
        int bl_err = 0;
        int hs_lo = 0;
        int vs_lo = 0;
        int bl_hi = 0;
        int fall = -1;
        int sd = 0;
        int c;
        logic prev_hs = 1'b1;
        logic e_hs;
        logic e_vs;
        logic e_bl;
        rst = 1'b0;
        for (int n = 1; n <= 198; n++) begin
            @(negedge clk);
            c = n - 3;
            e_hs = !(n >= 3 && (c % 14) >= 10 && (c % 14) < 12);
            e_vs = !(n >= 3 && ((c / 14) % 7) == 5);
            e_bl = exp_act(c);
            if (VGA_HSYNC !== e_hs) hs_err++;
            if (VGA_VSYNC !== e_vs) vs_err++;
            if (VGA_BLANK_N !== e_bl) bl_err++;
            if (VGA_HSYNC === 1'b0) hs_lo++;
            if (VGA_VSYNC === 1'b0) vs_lo++;
            if (VGA_BLANK_N === 1'b1) bl_hi++;
            if (prev_hs === 1'b1 && VGA_HSYNC === 1'b0 && fall < 0) fall = n;
            if (fb.swap_done === 1'b1) sd++;
            prev_hs = VGA_HSYNC;
        end
        chk({tag, "_hs_first_fall"}, fall, 13);
        chk({tag, "_hs_pattern"}, hs_err, 0);
        chk({tag, "_hs_low_cnt"}, hs_lo, 28);
        chk({tag, "_vs_pattern"}, vs_err, 0);
        chk({tag, "_vs_low_cnt"}, vs_lo, 28);
        chk({tag, "_blank_pattern"}, bl_err, 0);
        chk({tag, "_blank_hi_cnt"}, bl_hi, 64);
        chk({tag, "_no_swap"}, sd, 0);
        chk({tag, "_disp_bank"}, fb.disp_bank, 0);
    endtask

    initial begin
        int k;
        int err;
        int a;
        logic [11:0] d;
        rst = 1'b1;
        fb.wr_en = 1'b0;
        fb.wr_addr = '0;
        fb.wr_data = '0;
        fb.swap_req = 1'b0;
        dbank_m = 0;
        repeat (3) @(negedge clk);

        chk("rst_blank", VGA_BLANK_N, 0);
        chk("rst_hs", VGA_HSYNC, 1);
        chk("rst_vs", VGA_VSYNC, 1);
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_bank", fb.disp_bank, 0);
        chk("rst_done", fb.swap_done, 0);
        chk("rst_vblank", fb.vblank, 0);

        run_timing("t1");

        for (int i = 0; i < 8; i++) wr(i, 12'(16'h100 * i + 16'h0F0));
        pulse_req();
        wait_swap(k);
        chk("swap_h", cyc % 14, 0);
        chk("swap_v", (cyc / 14) % 7, 4);
        chk("swap_bank", fb.disp_bank, 1);
        chk("swap_vblank", fb.vblank, 1);
        dbank_m = 1;
        @(negedge clk);
        chk("swap_pulse_1cyc", fb.swap_done, 0);
        wait_st(3, 0);
        chk("pix_0_0", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
        wait_st(6, 2);
        chk("pix_3_2", {VGA_R, VGA_G, VGA_B}, 24'h55FF00);
        chk("act_vblank", fb.vblank, 0);
        wait_st(10, 3);
        chk("pix_7_3", {VGA_R, VGA_G, VGA_B}, 24'h77FF00);
        wait_st(0, 0);
        check_frame("frame_b1");

        for (int f = 0; f < 3; f++) begin
            err = 0;
            for (int i = 0; i < 98; i++) begin
                if ({VGA_R, VGA_G, VGA_B} !== exp_rgb(cyc - 3)) err++;
                a = i % 8;
                d = 12'($urandom);
                fb.wr_en = 1'b1;
                fb.wr_addr = 4'(a);
                fb.wr_data = d;
                mdl[1-dbank_m][a] = d;
                @(negedge clk);
            end
            chk("no_tear", err, 0);
        end
        fb.wr_en = 1'b0;

        wait_st(2, 0);
        pulse_req();
        wait_st(2, 1);
        pulse_req();
        wait_st(2, 3);
        pulse_req();
        k = 0;
        for (int i = 0; i < 98; i++) begin
            if (fb.swap_done === 1'b1) k++;
            @(negedge clk);
        end
        chk("coalesce_cnt", k, 1);
        chk("coalesce_bank", fb.disp_bank, 0);
        dbank_m = 0;

        wait_st(3, 5);
        pulse_req();
        wait_swap(k);
        chk("late_req_delay", k, 80);
        chk("late_req_bank", fb.disp_bank, 1);
        dbank_m = 1;

        wr(8, 12'hFFF);
        wait_st(13, 3);
        fb.swap_req = 1'b1;
        fb.wr_en = 1'b1;
        fb.wr_addr = 4'd2;
        fb.wr_data = 12'h123;
        mdl[0][2] = 12'h123;
        @(negedge clk);
        fb.swap_req = 1'b0;
        fb.wr_en = 1'b0;
        chk("swapcyc_done", fb.swap_done, 1);
        chk("swapcyc_bank", fb.disp_bank, 0);
        dbank_m = 0;
        wait_st(0, 0);
        check_frame("frame_b0_oob");
        pulse_req();
        wait_swap(k);
        chk("swap2_bank", fb.disp_bank, 1);
        dbank_m = 1;
        wait_st(0, 0);
        check_frame("frame_b1_again");

        wait_st(3, 0);
        pulse_req();
        wait_st(5, 2);
        chk("pre_rst_blank", VGA_BLANK_N, 1);
        rst = 1'b1;
        #1;
        chk("arst_blank", VGA_BLANK_N, 0);
        chk("arst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("arst_hs", VGA_HSYNC, 1);
        chk("arst_vs", VGA_VSYNC, 1);
        chk("arst_bank", fb.disp_bank, 0);
        repeat (2) @(negedge clk);
        dbank_m = 0;
        run_timing("t2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
